// File: rtl/rv_alu_pkg.sv
// Shared definitions for the rv_alu_mc ALU: opcode map, FSM states and width defaults.
package rv_alu_pkg;

   localparam int XLEN_DEF = 32;
   localparam int OPC_W    = 5;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_XOR    = 5'b00010;
   localparam logic [4:0] OP_OR     = 5'b00011;
   localparam logic [4:0] OP_AND    = 5'b00100;
   localparam logic [4:0] OP_SLL    = 5'b00101;
   localparam logic [4:0] OP_SRL    = 5'b00110;
   localparam logic [4:0] OP_SRA    = 5'b00111;
   localparam logic [4:0] OP_SLT    = 5'b01001;
   localparam logic [4:0] OP_SLTU   = 5'b01010;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_MULHU  = 5'b10011;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b10110;
   localparam logic [4:0] OP_REMU   = 5'b10111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

endpackage

// File: rtl/rv_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*XLEN working register.
// Operands are converted to magnitudes at start; the sign fix-up is applied on the last step.
module rv_muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);

   logic              run;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] prod, prod_nx, prod_fix;
   logic [XLEN-1:0]   opb, a_mag, b_mag, quo_fix, rem_fix, rem_diff;
   logic [XLEN:0]     add_sum, rem_sh;
   logic              div_q, hi_q, rem_q, neg_q, neg_r_q;
   logic              a_sgn, b_sgn, a_neg, b_neg, ge;

   always_comb begin
      if (op[2]) begin
         a_sgn = !op[0];
         b_sgn = !op[0];
      end else begin
         a_sgn = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
         b_sgn = (op[1:0] == 2'b01);
      end
      a_neg = a_sgn && rs1[XLEN-1];
      b_neg = b_sgn && rs2[XLEN-1];
      a_mag = a_neg ? -rs1 : rs1;
      b_mag = b_neg ? -rs2 : rs2;
   end

   // Multiply shifts right (multiplier in low half); divide shifts left (remainder in high half).
   always_comb begin
      add_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
      rem_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      ge       = (rem_sh >= {1'b0, opb});
      rem_diff = rem_sh[XLEN-1:0] - opb;
      if (div_q) prod_nx = {(ge ? rem_diff : rem_sh[XLEN-1:0]), prod[XLEN-2:0], ge};
      else       prod_nx = {add_sum, prod[XLEN-1:1]};
      prod_fix = neg_q ? -prod_nx : prod_nx;
      quo_fix  = neg_q ? -prod_nx[XLEN-1:0] : prod_nx[XLEN-1:0];
      rem_fix  = neg_r_q ? -prod_nx[2*XLEN-1:XLEN] : prod_nx[2*XLEN-1:XLEN];
      if (div_q) result = rem_q ? rem_fix : quo_fix;
      else       result = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
   end

   assign done = run && (cnt == CW'(XLEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run     <= 1'b0;
         cnt     <= '0;
         prod    <= '0;
         opb     <= '0;
         div_q   <= 1'b0;
         hi_q    <= 1'b0;
         rem_q   <= 1'b0;
         neg_q   <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (start) begin
         run     <= 1'b1;
         cnt     <= '0;
         prod    <= {{XLEN{1'b0}}, a_mag};
         opb     <= b_mag;
         div_q   <= op[2];
         hi_q    <= (op[1:0] != 2'b00);
         rem_q   <= op[1];
         neg_q   <= a_neg ^ b_neg;
         neg_r_q <= a_neg;
      end else if (run) begin
         prod <= prod_nx;
         cnt  <= cnt + 1'b1;
         if (done) run <= 1'b0;
      end
   end

endmodule

// File: rtl/rv_alu_mc.sv
// rv_alu_mc: single-issue integer ALU; base ops return one cycle after issue.
// Define RV_ALU_M_EN to build the iterative multiply/divide path; otherwise 10xxx returns zero.
module rv_alu_mc
   import rv_alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int OP_W = OPC_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op_in,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   output logic [XLEN-1:0] rd,
   output logic            comp_res,
   output logic            busy,
   output state_t          dbg_state
);
   // Handshake: a request transfers on a rising edge with in_valid && in_ready (in_ready only in
   // IDLE); out_valid pulses for one cycle per result and rd holds until the next pulse.
   localparam int SH_W = $clog2(XLEN);

   state_t          state;
   logic [XLEN-1:0] base_res, fast_res;
   logic [SH_W-1:0] shamt;

   assign shamt = rs2[SH_W-1:0];

   always_comb begin
      base_res = '0;
      case (op_in)
         OP_ADD:  base_res = rs1 + rs2;
         OP_SUB:  base_res = rs1 - rs2;
         OP_XOR:  base_res = rs1 ^ rs2;
         OP_OR:   base_res = rs1 | rs2;
         OP_AND:  base_res = rs1 & rs2;
         OP_SLL:  base_res = rs1 << shamt;
         OP_SRL:  base_res = rs1 >> shamt;
         OP_SRA:  base_res = $signed(rs1) >>> shamt;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
         default: base_res = '0;
      endcase
   end

`ifdef RV_ALU_M_EN
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic            is_m, is_div, is_rem, div_zero, div_ovf, iter_start, iter_done;
   logic [XLEN-1:0] iter_res;

   assign is_m       = (op_in[4:3] == 2'b10);
   assign is_div     = is_m && op_in[2];
   assign is_rem     = op_in[1];
   assign div_zero   = is_div && (rs2 == '0);
   assign div_ovf    = is_div && !op_in[0] && (rs1 == MOST_NEG) && (rs2 == '1);
   assign iter_start = in_valid && in_ready && is_m && !div_zero && !div_ovf;

   // Divide-by-zero and signed overflow resolve immediately, like a base op.
   always_comb begin
      fast_res = base_res;
      if (div_zero)     fast_res = is_rem ? rs1 : '1;
      else if (div_ovf) fast_res = is_rem ? '0 : rs1;
   end

   rv_muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (iter_start),
      .op     (op_in[2:0]),
      .rs1    (rs1),
      .rs2    (rs2),
      .done   (iter_done),
      .result (iter_res)
   );
`else
   assign fast_res = base_res;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         rd        <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
`ifdef RV_ALU_M_EN
               if (iter_start) begin
                  state <= is_div ? S_DIV : S_MUL;
               end else
`endif
               if (in_valid) begin
                  out_valid <= 1'b1;
                  rd        <= fast_res;
               end
            end
`ifdef RV_ALU_M_EN
            S_MUL, S_DIV: begin
               if (iter_done) begin
                  out_valid <= 1'b1;
                  rd        <= iter_res;
                  state     <= S_IDLE;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign busy      = !in_ready;
   assign comp_res  = rd[0];
   assign dbg_state = state;

endmodule

// File: tb/tb_rv_alu_mc.sv
// Bench for rv_alu_mc: directed vectors, back-to-back issue, mid-operation reset and random ops
// checked against an arithmetic reference model (M-extension expectations follow RV_ALU_M_EN).
module tb_rv_alu_mc;
   import rv_alu_pkg::*;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op_in;
   logic [XLEN-1:0] rs1, rs2;
   logic            out_valid;
   logic [XLEN-1:0] rd;
   logic            comp_res;
   logic            busy;
   state_t          dbg_state;

   always #5 clk = ~clk;

   rv_alu_mc #(.XLEN(XLEN), .OP_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_in     (op_in),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .rd        (rd),
      .comp_res  (comp_res),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [XLEN-1:0] exp_q[$];
   int              lat_q[$];
   int              acc_q[$];
   logic [4:0]      s_op[$];
   logic [XLEN-1:0] s_a[$];
   logic [XLEN-1:0] s_b[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic bit m_en();
`ifdef RV_ALU_M_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Reference result from the ISA arithmetic rules, using wide integer math.
   function automatic logic [XLEN-1:0] ref_rd(input logic [4:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] sa, sb, ua, ub, p;
      logic [XLEN-1:0]   r;
      int                sh;
      sa = {{XLEN{a[XLEN-1]}}, a};
      sb = {{XLEN{b[XLEN-1]}}, b};
      ua = {{XLEN{1'b0}}, a};
      ub = {{XLEN{1'b0}}, b};
      sh = int'(b % XLEN);
      r  = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_XOR:  r = a ^ b;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = XLEN'($signed(a) >>> sh);
         OP_SLT:  r = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
         OP_SLTU: r = (a < b) ? XLEN'(1) : '0;
         default: r = '0;
      endcase
      if (m_en()) begin
         case (op)
            OP_MUL:    begin p = ua * ub; r = p[XLEN-1:0];      end
            OP_MULH:   begin p = sa * sb; r = p[2*XLEN-1:XLEN]; end
            OP_MULHSU: begin p = sa * ub; r = p[2*XLEN-1:XLEN]; end
            OP_MULHU:  begin p = ua * ub; r = p[2*XLEN-1:XLEN]; end
            OP_DIV: begin
               if (b == '0) r = '1;
               else if (a == MIN_V && b == '1) r = a;
               else r = XLEN'($signed(a) / $signed(b));
            end
            OP_DIVU: r = (b == '0) ? '1 : a / b;
            OP_REM: begin
               if (b == '0) r = a;
               else if (a == MIN_V && b == '1) r = '0;
               else r = XLEN'($signed(a) % $signed(b));
            end
            OP_REMU: r = (b == '0) ? a : a % b;
            default: ;
         endcase
      end
      return r;
   endfunction

   function automatic int ref_lat(input logic [4:0] op, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
      if (!m_en() || op[4:3] != 2'b10) return 1;
      if (op[2] && b == '0) return 1;
      if (op[2] && !op[0] && a == MIN_V && b == '1) return 1;
      return XLEN + 1;
   endfunction

   task automatic add_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      s_op.push_back(op);
      s_a.push_back(a);
      s_b.push_back(b);
   endtask

   // Issue the queued ops with in_valid held, checking handshake, busy and every result.
   task automatic run_stream();
      int              idx = 0;
      int              cyc = 0;
      int              busy_end = -1;
      int              n;
      int              acc, lat;
      logic [XLEN-1:0] e;
      n = s_op.size();
      while ((idx < n || exp_q.size() != 0) && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         check("in_ready", in_ready, cyc > busy_end);
         check("busy", busy, cyc <= busy_end);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("extra_out_valid", out_valid, 1'b0);
            end else begin
               e   = exp_q.pop_front();
               acc = acc_q.pop_front();
               lat = lat_q.pop_front();
               check("rd", rd, e);
               check("comp_res", comp_res, e[0]);
               check("latency", cyc - acc, lat);
            end
         end
         if (idx < n) begin
            in_valid = 1'b1;
            op_in    = s_op[idx];
            rs1      = s_a[idx];
            rs2      = s_b[idx];
            if (in_ready) begin
               exp_q.push_back(ref_rd(s_op[idx], s_a[idx], s_b[idx]));
               lat = ref_lat(s_op[idx], s_a[idx], s_b[idx]);
               lat_q.push_back(lat);
               acc_q.push_back(cyc);
               if (lat > 1) busy_end = cyc + XLEN;
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("stream_pending", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
      s_op.delete();
      s_a.delete();
      s_b.delete();
   endtask

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return MIN_V;
         3:       return XLEN'($urandom_range(0, 15));
         default: return XLEN'($urandom);
      endcase
   endfunction

   logic [4:0] op_tab[21] = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA,
                              OP_SLT, OP_SLTU, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV,
                              OP_DIVU, OP_REM, OP_REMU, 5'b01000, 5'b01111, 5'b11000};

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int ov_seen;
      rst      = 1'b1;
      in_valid = 1'b0;
      op_in    = '0;
      rs1      = '0;
      rs2      = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_rd", rd, '0);
      check("rst_comp_res", comp_res, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbg_state, S_IDLE);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1'b1);

      // Directed vectors
      add_op(OP_SLT,  32'hFFFF_FFFF, 32'h0);
      add_op(OP_SLTU, 32'hFFFF_FFFF, 32'h0);
      add_op(OP_SRA,  32'h8000_0000, 32'h24);
      add_op(OP_MULH, 32'h8000_0000, 32'h8000_0000);
      add_op(OP_DIV,  -32'sd7, 32'd2);
      add_op(OP_REM,  -32'sd7, 32'd2);
      add_op(OP_DIVU, 32'h1234_5678, 32'h0);
      add_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      run_stream();

      // Back-to-back issue around an iterative op
      add_op(OP_ADD, 32'd10, 32'd20);
      add_op(OP_ADD, 32'hFFFF_FFFF, 32'd2);
      add_op(OP_MUL, 32'd12345, 32'd6789);
      add_op(OP_ADD, 32'd7, 32'd8);
      run_stream();

      // Reset in cycle 10 of a DIVU
      add_op(OP_ADD, 32'd5, 32'd6);
      run_stream();
      @(negedge clk);
      in_valid = 1'b1;
      op_in    = OP_DIVU;
      rs1      = 32'hDEAD_BEEF;
      rs2      = 32'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midop_rst_out_valid", out_valid, 1'b0);
      check("midop_rst_rd", rd, '0);
      check("midop_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", in_ready, 1'b1);
      check("rel_busy", busy, 1'b0);
      ov_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      check("aborted_no_out_valid", ov_seen, 0);
      check("aborted_rd", rd, '0);

      // Random mix
      for (int i = 0; i < 60; i++) begin
         add_op(op_tab[$urandom_range(0, 20)], rand_operand(), rand_operand());
      end
      run_stream();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
